// File: rtl/lab4_branch_resolve_queue.sv
// In-order queue of predicted conditional branches; resolves oldest-first and
// drives the registered predictor update port. Optional stats: LAB4_BRANCH_RESOLVE_STATS_EN.
module lab4_branch_resolve_queue #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enq_val,
  output logic          enq_rdy,
  input  logic [31:0]   enq_pc,
  input  logic          enq_pred,
  input  logic          res_val,
  input  logic          res_taken,
  input  logic          flush,
  output logic          upd_en,
  output logic          upd_val,
  output logic [31:0]   upd_pc,
  output logic          mispredict,
  output logic [CW-1:0] count
`ifdef LAB4_BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]   stat_resolved,
  output logic [31:0]   stat_mispred
`endif
);

  logic [31:0] pc_mem   [DEPTH];
  logic        pred_mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic enq_fire, res_fire, mis_fire, enq_keep;

  assign enq_rdy  = (count != CW'(DEPTH));
  assign enq_fire = enq_val && enq_rdy;
  assign res_fire = res_val && (count != '0);
  assign mis_fire = res_fire && (res_taken != pred_mem[head]);
  // An enqueue alongside a squash or flush is wrong-path and is discarded.
  assign enq_keep = enq_fire && !mis_fire && !flush;

  always_ff @(posedge clk) begin
    if (enq_keep) begin
      pc_mem[tail]   <= enq_pc;
      pred_mem[tail] <= enq_pred;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      upd_en     <= 1'b0;
      upd_val    <= 1'b0;
      upd_pc     <= '0;
      mispredict <= 1'b0;
    end else begin
      upd_en     <= res_fire;
      mispredict <= mis_fire;
      if (res_fire) begin
        upd_val <= res_taken;
        upd_pc  <= pc_mem[head];
      end
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else if (mis_fire) begin
        // Everything younger than the mispredicted branch is squashed.
        head  <= head + PW'(1);
        tail  <= head + PW'(1);
        count <= '0;
      end else begin
        if (res_fire) head <= head + PW'(1);
        if (enq_keep) tail <= tail + PW'(1);
        count <= count + CW'(enq_keep) - CW'(res_fire);
      end
    end
  end

`ifdef LAB4_BRANCH_RESOLVE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (res_fire && stat_resolved != 32'hFFFF_FFFF) stat_resolved <= stat_resolved + 32'd1;
      if (mis_fire && stat_mispred != 32'hFFFF_FFFF) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lab4_branch_resolve_queue.sv
// Directed self-checking bench for lab4_branch_resolve_queue (DEPTH=4).
module tb_lab4_branch_resolve_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enq_val = 1'b0, enq_pred = 1'b0, res_val = 1'b0, res_taken = 1'b0, flush = 1'b0;
  logic [31:0] enq_pc = '0;
  logic        enq_rdy, upd_en, upd_val, mispredict;
  logic [31:0] upd_pc;
  logic [2:0]  count;
`ifdef LAB4_BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_resolved, stat_mispred;
`endif
  int n_tests = 0;
  int n_fail  = 0;

  lab4_branch_resolve_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_pc(enq_pc), .enq_pred(enq_pred),
    .res_val(res_val), .res_taken(res_taken), .flush(flush),
    .upd_en(upd_en), .upd_val(upd_val), .upd_pc(upd_pc),
    .mispredict(mispredict), .count(count)
`ifdef LAB4_BRANCH_RESOLVE_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] pc, input logic p);
    enq_val = 1'b1; enq_pc = pc; enq_pred = p;
    cyc();
    enq_val = 1'b0;
  endtask

  task automatic res(input logic t);
    res_val = 1'b1; res_taken = t;
    cyc();
    res_val = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_count", count, 0);
    chk("rst_upd_en", upd_en, 0);
    chk("rst_upd_pc", upd_pc, 0);
    chk("rst_mis", mispredict, 0);
    chk("rst_rdy", enq_rdy, 1);
    reset = 1'b0;
    cyc();

    // 1: single correct prediction
    enq(32'h100, 1'b1);
    chk("t1_count1", count, 1);
    res(1'b1);
    chk("t1_upd_en", upd_en, 1);
    chk("t1_upd_val", upd_val, 1);
    chk("t1_upd_pc", upd_pc, 32'h100);
    chk("t1_mis", mispredict, 0);
    chk("t1_count0", count, 0);
    cyc();
    chk("t1_pulse_end", upd_en, 0);
    chk("t1_pc_hold", upd_pc, 32'h100);
    chk("t1_val_hold", upd_val, 1);

    // 2: fill, full, resolve+enq while full
    for (int i = 0; i < 4; i++) enq(32'h10 + 32'(4*i), 1'b1);
    chk("t2_full_rdy", enq_rdy, 0);
    chk("t2_full_count", count, 4);
    enq_val = 1'b1; enq_pc = 32'h20; enq_pred = 1'b1;
    res(1'b1);
    enq_val = 1'b0;
    chk("t2_count3", count, 3);
    chk("t2_upd_pc0", upd_pc, 32'h10);
    chk("t2_mis0", mispredict, 0);
    for (int i = 1; i < 4; i++) begin
      res(1'b1);
      chk("t2_drain_pc", upd_pc, 32'h10 + 32'(4*i));
    end
    chk("t2_empty", count, 0);

    // 3: mispredict squash with a same-cycle enqueue
    enq(32'h200, 1'b0);
    enq(32'h204, 1'b1);
    enq(32'h208, 1'b1);
    enq_val = 1'b1; enq_pc = 32'h20C; enq_pred = 1'b1;
    res(1'b1);
    enq_val = 1'b0;
    chk("t3_mis", mispredict, 1);
    chk("t3_upd_en", upd_en, 1);
    chk("t3_upd_pc", upd_pc, 32'h200);
    chk("t3_upd_val", upd_val, 1);
    chk("t3_count", count, 0);
    res(1'b0);
    chk("t3_ign_upd_en", upd_en, 0);
    chk("t3_ign_mis", mispredict, 0);
    chk("t3_ign_pc", upd_pc, 32'h200);
    enq(32'h300, 1'b0);
    res(1'b0);
    chk("t3_after_pc", upd_pc, 32'h300);
    chk("t3_after_mis", mispredict, 0);
    chk("t3_after_val", upd_val, 0);

    // 4: flush with resolve and enqueue in the same cycle
    enq(32'h400, 1'b1);
    enq(32'h404, 1'b1);
    flush = 1'b1; enq_val = 1'b1; enq_pc = 32'h408; enq_pred = 1'b0;
    res(1'b0);
    flush = 1'b0; enq_val = 1'b0;
    chk("t4_upd_en", upd_en, 1);
    chk("t4_upd_pc", upd_pc, 32'h400);
    chk("t4_upd_val", upd_val, 0);
    chk("t4_mis", mispredict, 1);
    chk("t4_count", count, 0);
    enq(32'h500, 1'b1);
    res(1'b1);
    chk("t4_after_pc", upd_pc, 32'h500);
    chk("t4_after_mis", mispredict, 0);

    // 5: pointer wrap over six pairs, then async reset mid-stream
    for (int i = 0; i < 6; i++) begin
      enq(32'h600 + 32'(4*i), 1'(i % 2));
      res(1'(i % 2));
      chk("t5_wrap_pc", upd_pc, 32'h600 + 32'(4*i));
      chk("t5_wrap_mis", mispredict, 0);
    end
    enq(32'h700, 1'b1);
    enq(32'h704, 1'b0);
    res(1'b0);
    chk("t5_pre_mis", mispredict, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_upd_en", upd_en, 0);
    chk("t5_rst_mis", mispredict, 0);
    chk("t5_rst_pc", upd_pc, 0);
    chk("t5_rst_count", count, 0);
    #2 reset = 1'b0;
    cyc();

`ifdef LAB4_BRANCH_RESOLVE_STATS_EN
    // 6: statistics counters
    chk("t6_rst_res", stat_resolved, 0);
    chk("t6_rst_mis", stat_mispred, 0);
    enq(32'h800, 1'b1);
    enq(32'h804, 1'b1);
    enq(32'h808, 1'b0);
    res(1'b1);
    res(1'b1);
    res(1'b1);
    chk("t6_same_cycle", upd_en, 1);
    chk("t6_resolved", stat_resolved, 3);
    chk("t6_mispred", stat_mispred, 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    chk("t6_flush_res", stat_resolved, 3);
    chk("t6_flush_mis", stat_mispred, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
